// File: rtl/mprc_meta_pkg.sv
// Shared sizing, coherence encoding and FSM state type for the metadata lookup block.
package mprc_meta_pkg;

  localparam int NWAYS = 4;
  localparam int IDX_W = 6;
  localparam int TAG_W = 20;
  localparam int COH_W = 2;

  // A way whose coherence state equals this value holds no valid line.
  localparam logic [COH_W-1:0] COH_INVALID = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMP  = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mprc_way_select.sv
// Combinational hit detection and victim choice over one set's worth of metadata.
// On a hit the lowest-index hitting way wins; on a miss the lowest-index invalid
// way is the victim, falling back to the round-robin pointer when every way is valid.
module mprc_way_select #(
  parameter int NWAYS = mprc_meta_pkg::NWAYS,
  parameter int TAG_W = mprc_meta_pkg::TAG_W,
  parameter int COH_W = mprc_meta_pkg::COH_W,
  parameter int PTR_W = $clog2(NWAYS)
) (
  input  logic [NWAYS*TAG_W-1:0] way_tag_i,
  input  logic [NWAYS*COH_W-1:0] way_coh_i,
  input  logic [TAG_W-1:0]       cmp_tag_i,
  input  logic [PTR_W-1:0]       rr_ptr_i,
  output logic                   hit_o,
  output logic                   all_valid_o,
  output logic [NWAYS-1:0]       way_en_o,
  output logic [COH_W-1:0]       coh_state_o,
  output logic [TAG_W-1:0]       victim_tag_o,
  output logic [COH_W-1:0]       victim_coh_o
);
  import mprc_meta_pkg::*;

  logic [TAG_W-1:0] way_tag_s [NWAYS];
  logic [COH_W-1:0] way_coh_s [NWAYS];
  logic [PTR_W-1:0] hit_idx_s;
  logic [PTR_W-1:0] inv_idx_s;
  logic [PTR_W-1:0] vic_idx_s;
  logic [NWAYS-1:0] one_s;

  for (genvar g = 0; g < NWAYS; g++) begin : g_unpack
    assign way_tag_s[g] = way_tag_i[g*TAG_W +: TAG_W];
    assign way_coh_s[g] = way_coh_i[g*COH_W +: COH_W];
  end

  assign one_s = {{(NWAYS-1){1'b0}}, 1'b1};

  // Scan ways from high to low so the lowest-index match is the one left standing.
  always_comb begin
    hit_o        = 1'b0;
    all_valid_o  = 1'b1;
    hit_idx_s    = '0;
    inv_idx_s    = '0;
    vic_idx_s    = '0;
    way_en_o     = '0;
    coh_state_o  = '0;
    victim_tag_o = '0;
    victim_coh_o = '0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (way_coh_s[i] != COH_INVALID) begin
        if (way_tag_s[i] == cmp_tag_i) begin
          hit_o     = 1'b1;
          hit_idx_s = PTR_W'(i);
        end else begin
          hit_idx_s = hit_idx_s;
        end
      end else begin
        all_valid_o = 1'b0;
        inv_idx_s   = PTR_W'(i);
      end
    end
    if (hit_o) begin
      way_en_o    = one_s << hit_idx_s;
      coh_state_o = way_coh_s[hit_idx_s];
    end else begin
      vic_idx_s    = all_valid_o ? rr_ptr_i : inv_idx_s;
      way_en_o     = one_s << vic_idx_s;
      victim_tag_o = way_tag_s[vic_idx_s];
      victim_coh_o = way_coh_s[vic_idx_s];
    end
  end

endmodule

// File: rtl/mprc_meta_lookup.sv
// Cache metadata lookup: arbitrates fills against lookups onto an external
// tag/state array, compares the returned set and reports hit or victim.
module mprc_meta_lookup #(
  parameter int NWAYS = mprc_meta_pkg::NWAYS,
  parameter int IDX_W = mprc_meta_pkg::IDX_W,
  parameter int TAG_W = mprc_meta_pkg::TAG_W,
  parameter int COH_W = mprc_meta_pkg::COH_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [IDX_W-1:0]       req_idx,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic [NWAYS-1:0]       resp_way_en,
  output logic [COH_W-1:0]       resp_coh_state,
  output logic [TAG_W-1:0]       resp_victim_tag,
  output logic [COH_W-1:0]       resp_victim_coh_state,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [IDX_W-1:0]       fill_idx,
  input  logic [NWAYS-1:0]       fill_way_en,
  input  logic [TAG_W-1:0]       fill_tag,
  input  logic [COH_W-1:0]       fill_coh_state,
  output logic                   meta_read_valid,
  input  logic                   meta_read_ready,
  output logic [IDX_W-1:0]       meta_read_idx,
  output logic [NWAYS-1:0]       meta_read_way_en,
  output logic                   meta_write_valid,
  input  logic                   meta_write_ready,
  output logic [IDX_W-1:0]       meta_write_idx,
  output logic [NWAYS-1:0]       meta_write_way_en,
  output logic [TAG_W-1:0]       meta_write_tag,
  output logic [COH_W-1:0]       meta_write_coh_state,
  input  logic [NWAYS*TAG_W-1:0] meta_resp_tag,
  input  logic [NWAYS*COH_W-1:0] meta_resp_coh_state
);
  import mprc_meta_pkg::*;

  localparam int PTR_W = $clog2(NWAYS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q, resp_hit_d;
  logic [NWAYS-1:0] resp_way_en_q, resp_way_en_d;
  logic [COH_W-1:0] resp_coh_q, resp_coh_d;
  logic [TAG_W-1:0] resp_vtag_q, resp_vtag_d;
  logic [COH_W-1:0] resp_vcoh_q, resp_vcoh_d;

  logic             sel_hit_s;
  logic             sel_all_valid_s;
  logic [NWAYS-1:0] sel_way_en_s;
  logic [COH_W-1:0] sel_coh_s;
  logic [TAG_W-1:0] sel_vtag_s;
  logic [COH_W-1:0] sel_vcoh_s;

  mprc_way_select #(
    .NWAYS (NWAYS),
    .TAG_W (TAG_W),
    .COH_W (COH_W),
    .PTR_W (PTR_W)
  ) u_way_select (
    .way_tag_i    (meta_resp_tag),
    .way_coh_i    (meta_resp_coh_state),
    .cmp_tag_i    (tag_q),
    .rr_ptr_i     (rr_q),
    .hit_o        (sel_hit_s),
    .all_valid_o  (sel_all_valid_s),
    .way_en_o     (sel_way_en_s),
    .coh_state_o  (sel_coh_s),
    .victim_tag_o (sel_vtag_s),
    .victim_coh_o (sel_vcoh_s)
  );

  // Fill payload goes straight to the array write port; the read always covers the whole set.
  assign meta_write_idx        = fill_idx;
  assign meta_write_way_en     = fill_way_en;
  assign meta_write_tag        = fill_tag;
  assign meta_write_coh_state  = fill_coh_state;
  assign meta_read_way_en      = {NWAYS{1'b1}};
  assign meta_read_idx         = (state_q == IDLE) ? req_idx : idx_q;

  assign resp_valid            = resp_valid_q;
  assign resp_hit              = resp_hit_q;
  assign resp_way_en           = resp_way_en_q;
  assign resp_coh_state        = resp_coh_q;
  assign resp_victim_tag       = resp_vtag_q;
  assign resp_victim_coh_state = resp_vcoh_q;

  // Next-state, handshake and array-port control; fills win over lookups in IDLE.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    tag_d            = tag_q;
    rr_d             = rr_q;
    resp_valid_d     = resp_valid_q;
    resp_hit_d       = resp_hit_q;
    resp_way_en_d    = resp_way_en_q;
    resp_coh_d       = resp_coh_q;
    resp_vtag_d      = resp_vtag_q;
    resp_vcoh_d      = resp_vcoh_q;
    req_ready        = 1'b0;
    fill_ready       = 1'b0;
    meta_read_valid  = 1'b0;
    meta_write_valid = 1'b0;
    case (state_q)
      IDLE: begin
        fill_ready       = meta_write_ready;
        meta_write_valid = fill_valid & meta_write_ready;
        if (fill_valid) begin
          req_ready = 1'b0;
        end else begin
          req_ready = meta_read_ready;
          if (req_valid && meta_read_ready) begin
            meta_read_valid = 1'b1;
            idx_d           = req_idx;
            tag_d           = req_tag;
            state_d         = CMP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CMP: begin
        resp_valid_d  = 1'b1;
        resp_hit_d    = sel_hit_s;
        resp_way_en_d = sel_way_en_s;
        resp_coh_d    = sel_coh_s;
        resp_vtag_d   = sel_vtag_s;
        resp_vcoh_d   = sel_vcoh_s;
        if (!sel_hit_s && sel_all_valid_s) begin
          rr_d = rr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
          rr_d = rr_q;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State, latched request and registered response, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      tag_q         <= '0;
      rr_q          <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_en_q <= '0;
      resp_coh_q    <= '0;
      resp_vtag_q   <= '0;
      resp_vcoh_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tag_q         <= tag_d;
      rr_q          <= rr_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_way_en_q <= resp_way_en_d;
      resp_coh_q    <= resp_coh_d;
      resp_vtag_q   <= resp_vtag_d;
      resp_vcoh_q   <= resp_vcoh_d;
    end
  end

endmodule

// File: tb/tb_mprc_meta_lookup.sv
// Scoreboard bench for mprc_meta_lookup: a behavioural tag/state array sits on the
// meta ports, expected responses are queued at request acceptance and a monitor
// compares them against the response handshake.
module tb_mprc_meta_lookup;

  typedef struct {
    logic        hit;
    logic [3:0]  way;
    logic [1:0]  coh;
    logic [19:0] vtag;
    logic [1:0]  vcoh;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [5:0]  req_idx;
  logic [19:0] req_tag;
  logic        resp_valid, resp_ready, resp_hit;
  logic [3:0]  resp_way_en;
  logic [1:0]  resp_coh_state;
  logic [19:0] resp_victim_tag;
  logic [1:0]  resp_victim_coh_state;
  logic        fill_valid, fill_ready;
  logic [5:0]  fill_idx;
  logic [3:0]  fill_way_en;
  logic [19:0] fill_tag;
  logic [1:0]  fill_coh_state;
  logic        meta_read_valid, meta_read_ready;
  logic [5:0]  meta_read_idx;
  logic [3:0]  meta_read_way_en;
  logic        meta_write_valid, meta_write_ready;
  logic [5:0]  meta_write_idx;
  logic [3:0]  meta_write_way_en;
  logic [19:0] meta_write_tag;
  logic [1:0]  meta_write_coh_state;
  logic [79:0] meta_resp_tag;
  logic [7:0]  meta_resp_coh_state;

  bit [19:0] mem_tag [64][4];
  bit [1:0]  mem_coh [64][4];
  exp_t      exp_q [$];
  int        ref_rr = 0;
  int        cyc = 0;
  int        n_checks = 0;
  int        n_errors = 0;
  int        resp_mode = 1;
  int        meta_mode = 0;

  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_hit = 1'b0;
  logic [3:0]  prev_way = 4'd0;
  logic [1:0]  prev_coh = 2'd0, prev_vcoh = 2'd0;
  logic [19:0] prev_vtag = 20'd0;

  mprc_meta_lookup dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way_en(resp_way_en), .resp_coh_state(resp_coh_state),
    .resp_victim_tag(resp_victim_tag), .resp_victim_coh_state(resp_victim_coh_state),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_idx(fill_idx),
    .fill_way_en(fill_way_en), .fill_tag(fill_tag), .fill_coh_state(fill_coh_state),
    .meta_read_valid(meta_read_valid), .meta_read_ready(meta_read_ready),
    .meta_read_idx(meta_read_idx), .meta_read_way_en(meta_read_way_en),
    .meta_write_valid(meta_write_valid), .meta_write_ready(meta_write_ready),
    .meta_write_idx(meta_write_idx), .meta_write_way_en(meta_write_way_en),
    .meta_write_tag(meta_write_tag), .meta_write_coh_state(meta_write_coh_state),
    .meta_resp_tag(meta_resp_tag), .meta_resp_coh_state(meta_resp_coh_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic [3:0] w, input logic [1:0] c,
                              input logic [19:0] vt, input logic [1:0] vc);
    exp_t e;
    e.hit = h; e.way = w; e.coh = c; e.vtag = vt; e.vcoh = vc; e.acc = 0;
    return e;
  endfunction

  // Reference: lowest valid matching way hits; otherwise lowest invalid way,
  // or the round-robin way (which then advances) when the whole set is valid.
  function automatic exp_t model(input int idx, input logic [19:0] tag);
    exp_t e;
    int hw, iw, v;
    logic [3:0] one;
    one = 4'b0001; hw = -1; iw = -1;
    e = mk(1'b0, 4'd0, 2'd0, 20'd0, 2'd0);
    for (int w = 0; w < 4; w++) begin
      if (hw < 0 && mem_coh[idx][w] != 2'b00 && mem_tag[idx][w] == tag) hw = w;
      if (iw < 0 && mem_coh[idx][w] == 2'b00) iw = w;
    end
    if (hw >= 0) begin
      e.hit = 1'b1; e.way = one << hw; e.coh = mem_coh[idx][hw];
    end else begin
      if (iw >= 0) v = iw;
      else begin
        v = ref_rr;
        ref_rr = (ref_rr + 1) % 4;
      end
      e.way = one << v; e.vtag = mem_tag[idx][v]; e.vcoh = mem_coh[idx][v];
    end
    return e;
  endfunction

  // Behavioural metadata array: writes on accepted write, read data the cycle after an accepted read.
  always @(posedge clk) begin
    if (meta_write_valid && meta_write_ready) begin
      for (int w = 0; w < 4; w++) begin
        if (meta_write_way_en[w]) begin
          mem_tag[meta_write_idx][w] <= meta_write_tag;
          mem_coh[meta_write_idx][w] <= meta_write_coh_state;
        end
      end
    end
    if (meta_read_valid && meta_read_ready) begin
      for (int w = 0; w < 4; w++) begin
        meta_resp_tag[w*20 +: 20]     <= mem_tag[meta_read_idx][w];
        meta_resp_coh_state[w*2 +: 2] <= mem_coh[meta_read_idx][w];
      end
    end
  end

  // Response-ready driver.
  initial forever begin
    @(posedge clk); #1;
    case (resp_mode)
      0: resp_ready = 1'b0;
      1: resp_ready = 1'b1;
      default: resp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Array-ready driver.
  initial forever begin
    @(posedge clk); #1;
    case (meta_mode)
      0: begin meta_read_ready = 1'b0; meta_write_ready = 1'b0; end
      1: begin meta_read_ready = 1'b1; meta_write_ready = 1'b1; end
      default: begin
        meta_read_ready  = ($urandom_range(0, 4) != 0);
        meta_write_ready = ($urandom_range(0, 4) != 0);
      end
    endcase
  end

  // Monitor: protocol rules, latency, stall stability and scoreboard compare.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (meta_read_valid || meta_write_valid)
        chk("rd_wr_exclusive", 32'(meta_read_valid & meta_write_valid), 32'd0);
      if (meta_read_valid) chk("read_way_en", 32'(meta_read_way_en), 32'hf);
      if (req_valid && !meta_read_ready) chk("req_ready_array_busy", 32'(req_ready), 32'd0);
      if (fill_valid && !meta_write_ready) chk("fill_ready_array_busy", 32'(fill_ready), 32'd0);
      if (resp_valid) begin
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        chk("fill_ready_in_resp", 32'(fill_ready), 32'd0);
        if (!prev_valid) begin
          chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("latency", 32'(cyc - exp_q[0].acc), 32'd2);
        end else if (!prev_ready) begin
          chk("stable_hit", 32'(resp_hit), 32'(prev_hit));
          chk("stable_way", 32'(resp_way_en), 32'(prev_way));
          chk("stable_coh", 32'(resp_coh_state), 32'(prev_coh));
          chk("stable_vtag", 32'(resp_victim_tag), 32'(prev_vtag));
          chk("stable_vcoh", 32'(resp_victim_coh_state), 32'(prev_vcoh));
        end
        if (resp_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_hit", 32'(resp_hit), 32'(e.hit));
          chk("resp_way_en", 32'(resp_way_en), 32'(e.way));
          chk("resp_coh_state", 32'(resp_coh_state), 32'(e.coh));
          chk("resp_victim_tag", 32'(resp_victim_tag), 32'(e.vtag));
          chk("resp_victim_coh", 32'(resp_victim_coh_state), 32'(e.vcoh));
        end
      end
      prev_valid <= resp_valid; prev_ready <= resp_ready; prev_hit <= resp_hit;
      prev_way <= resp_way_en; prev_coh <= resp_coh_state;
      prev_vtag <= resp_victim_tag; prev_vcoh <= resp_victim_coh_state;
    end
  end

  // Issue one lookup; the expected result is queued at the acceptance cycle.
  task automatic do_req(input logic [5:0] idx, input logic [19:0] tag,
                        input bit use_exp, input exp_t dexp, output int waited);
    exp_t e;
    bit done;
    done = 1'b0; waited = 0;
    req_idx = idx; req_tag = tag; req_valid = 1'b1;
    while (!done && waited < 400) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        e = model(int'(idx), tag);
        if (use_exp) e = dexp;
        e.acc = cyc;
        exp_q.push_back(e);
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("req_accepted", 32'(done), 32'd1);
  endtask

  task automatic do_fill(input logic [5:0] idx, input logic [3:0] way,
                         input logic [19:0] tag, input logic [1:0] coh);
    bit done;
    int n;
    done = 1'b0; n = 0;
    fill_idx = idx; fill_way_en = way; fill_tag = tag; fill_coh_state = coh; fill_valid = 1'b1;
    while (!done && n < 400) begin
      @(negedge clk);
      if (fill_ready) done = 1'b1;
      else n++;
      @(posedge clk); #1;
    end
    fill_valid = 1'b0;
    chk("fill_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_resp_valid();
    int n;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("resp_valid_seen", 32'(resp_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_t       dx;
    int         waited;
    logic [3:0] one;
    logic [5:0] ridx;
    logic [19:0] rtag;
    one = 4'b0001;
    dx = mk(1'b0, 4'd0, 2'd0, 20'd0, 2'd0);
    reset = 1'b0; req_valid = 1'b0; req_idx = 6'd0; req_tag = 20'd0;
    fill_valid = 1'b0; fill_idx = 6'd0; fill_way_en = 4'd0; fill_tag = 20'd0; fill_coh_state = 2'd0;
    resp_ready = 1'b0; meta_read_ready = 1'b0; meta_write_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_resp_way_en", 32'(resp_way_en), 32'd0);
    chk("rst_resp_coh", 32'(resp_coh_state), 32'd0);
    chk("rst_resp_vtag", 32'(resp_victim_tag), 32'd0);
    chk("rst_resp_vcoh", 32'(resp_victim_coh_state), 32'd0);
    reset = 1'b1;

    // Array initialising for 64 cycles with a request pending; accepted on the 65th.
    req_idx = 6'd0; req_tag = 20'h12345; req_valid = 1'b1;
    repeat (64) begin
      @(negedge clk);
      chk("init_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    meta_mode = 1; meta_read_ready = 1'b1; meta_write_ready = 1'b1;
    do_req(6'd0, 20'h12345, 1'b0, dx, waited);
    chk("init_accept_wait", 32'(waited), 32'd0);
    wait_drain();

    // Fill then hit.
    do_fill(6'd5, 4'b0100, 20'hABCDE, 2'b11);
    do_req(6'd5, 20'hABCDE, 1'b1, mk(1'b1, 4'b0100, 2'b11, 20'd0, 2'd0), waited);
    wait_drain();

    // Miss with ways 0 and 1 valid: first invalid way is the victim.
    do_fill(6'd7, 4'b0001, 20'h11111, 2'b01);
    do_fill(6'd7, 4'b0010, 20'h22222, 2'b10);
    do_req(6'd7, 20'h33333, 1'b1, mk(1'b0, 4'b0100, 2'b00, 20'd0, 2'd0), waited);
    wait_drain();

    // All-valid set: round-robin victims 0,1,2,3 then wrap to 0.
    for (int w = 0; w < 4; w++) do_fill(6'd9, one << w, 20'h90000 + 20'(w), 2'((w % 3) + 1));
    for (int k = 0; k < 5; k++) begin
      do_req(6'd9, 20'hFFFFF, 1'b1,
             mk(1'b0, one << (k % 4), 2'd0, 20'h90000 + 20'(k % 4), 2'(((k % 4) % 3) + 1)), waited);
      wait_drain();
    end

    // Two ways hold the same tag: lowest index wins.
    do_fill(6'd3, 4'b1010, 20'h33333, 2'b01);
    do_req(6'd3, 20'h33333, 1'b1, mk(1'b1, 4'b0010, 2'b01, 20'd0, 2'd0), waited);
    wait_drain();

    // Fill and lookup together: fill first, lookup next cycle sees the fill.
    fill_idx = 6'd20; fill_way_en = 4'b0001; fill_tag = 20'h55555; fill_coh_state = 2'b10; fill_valid = 1'b1;
    req_idx = 6'd20; req_tag = 20'h55555; req_valid = 1'b1;
    @(negedge clk);
    chk("both_fill_ready", 32'(fill_ready), 32'd1);
    chk("both_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    do_req(6'd20, 20'h55555, 1'b1, mk(1'b1, 4'b0001, 2'b10, 20'd0, 2'd0), waited);
    chk("both_req_next_cycle", 32'(waited), 32'd0);
    wait_drain();

    // Response held for 5 cycles by resp_ready=0.
    resp_mode = 0; resp_ready = 1'b0;
    do_req(6'd5, 20'hABCDE, 1'b0, dx, waited);
    wait_resp_valid();
    repeat (5) begin
      @(negedge clk);
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
    end
    @(posedge clk); #1;
    resp_mode = 1; resp_ready = 1'b1;
    wait_drain();

    // Reset while the response is presented.
    resp_mode = 0; resp_ready = 1'b0;
    do_req(6'd7, 20'h11111, 1'b0, dx, waited);
    wait_resp_valid();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_resp_drop", 32'(resp_valid), 32'd0);
    chk("rst_resp_no_write", 32'(meta_write_valid), 32'd0);
    exp_q.delete(); ref_rr = 0;
    @(posedge clk); #1;
    reset = 1'b1; resp_mode = 1; resp_ready = 1'b1;

    // Reset during the compare cycle of an all-valid miss.
    do_req(6'd9, 20'hFFFFF, 1'b0, dx, waited);
    reset = 1'b0;
    #1;
    chk("rst_cmp_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_cmp_no_write", 32'(meta_write_valid), 32'd0);
    chk("rst_cmp_no_read", 32'(meta_read_valid), 32'd0);
    exp_q.delete(); ref_rr = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cmp_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    do_req(6'd9, 20'hFFFFF, 1'b1, mk(1'b0, 4'b0001, 2'd0, 20'h90000, 2'b01), waited);
    wait_drain();

    // Randomized traffic with array and response back-pressure.
    meta_mode = 2; resp_mode = 2;
    for (int it = 0; it < 150; it++) begin
      ridx = 6'($urandom_range(0, 3));
      rtag = 20'($urandom_range(1, 5));
      if ($urandom_range(0, 2) == 0)
        do_fill(ridx, 4'($urandom_range(0, 15)), rtag, 2'($urandom_range(0, 3)));
      else
        do_req(ridx, rtag, 1'b0, dx, waited);
    end
    wait_drain();
    meta_mode = 1; resp_mode = 1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mprc_meta_lookup.md
MPRC_META_LOOKUP -- requirements
Module: mprc_meta_lookup

Interface
REQ-001 SHALL have parameters:
- NWAYS, 4, ways per set
- IDX_W, 6, set index width
- TAG_W, 20, tag width
- COH_W, 2, coherence-state width
REQ-002 SHALL have these ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid/req_ready  in/out  1  lookup handshake
- req_idx/req_tag  in  6/20  lookup set and tag
- resp_valid/resp_ready  out/in  1  result handshake
- resp_hit  out  1  tag hit
- resp_way_en  out  4  one-hot hit way, or victim way on miss
- resp_coh_state  out  2  state of hit way (0 on miss)
- resp_victim_tag/resp_victim_coh_state  out  20/2  victim contents on miss (0 on hit)
- fill_valid/fill_ready  in/out  1  metadata update handshake
- fill_idx/fill_way_en/fill_tag/fill_coh_state  in  6/4/20/2  update payload
- meta_read_valid/meta_read_ready  out/in  1  array read port
- meta_read_idx/meta_read_way_en  out  6/4  read set; way_en always 4'hf
- meta_write_valid/meta_write_ready  out/in  1  array write port
- meta_write_idx/meta_write_way_en/meta_write_tag/meta_write_coh_state  out  6/4/20/2  write payload
- meta_resp_tag/meta_resp_coh_state  in  80/8  way i at tag[20i+19:20i], state[2i+1:2i]; valid the cycle after an accepted read
REQ-003 SHALL use one clock and an asynchronous active-low reset named reset.

Function
REQ-004 SHALL have FSM states IDLE, CMP, RESP.
REQ-005 In IDLE, fill SHALL have priority: fill_ready = meta_write_ready when in IDLE, else 0; meta_write_valid = fill_valid & fill_ready, with the payload passed through combinationally.
REQ-006 In IDLE with no fill_valid: req_ready = meta_read_ready; on req_valid & req_ready, SHALL assert meta_read_valid with meta_read_idx = req_idx, latch idx and tag, and go to CMP.
REQ-007 meta_read_valid and meta_write_valid SHALL never be high in the same cycle.
REQ-008 SHALL drive req_ready and fill_ready to 0 outside IDLE.
REQ-009 SHALL treat a way as valid when coh_state != 0; hit = valid and tag == latched tag.
REQ-010 In CMP, SHALL register the result, set resp_valid, and go to RESP; lookup latency from request acceptance to resp_valid is 2 cycles.
REQ-011 On hit, resp_way_en SHALL select the lowest-index hitting way; multiple hits resolve the same way.
REQ-012 On miss, SHALL choose the lowest-index invalid way as victim; if all ways are valid, SHALL choose the way at the 2-bit round-robin pointer.
REQ-013 The round-robin pointer SHALL increment, wrapping 3->0, only on an all-valid miss.
REQ-014 In RESP, SHALL hold all resp_* outputs stable until resp_ready; on resp_valid & resp_ready, SHALL clear resp_valid and return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-015 While the array is initialising (meta_read_ready = meta_write_ready = 0), req_ready and fill_ready SHALL stay 0 and no request SHALL be lost.
REQ-016 A fill SHALL be visible to any lookup accepted in a later cycle.

Reset
REQ-017 On reset low, SHALL force the FSM to IDLE, the RR pointer to 0, and all registered outputs and latched fields to 0, asynchronously.
REQ-018 Reset asserted mid-lookup SHALL drop resp_valid immediately, with no array write issued.

Structure
REQ-019 Package mprc_meta_pkg SHALL hold NWAYS, IDX_W, TAG_W, COH_W, COH_INVALID = 2'b00, and the FSM state type.
REQ-020 Hit detection and victim priority encoding SHALL live in sub-module mprc_way_select, which is purely combinational.

Verification
REQ-021 Scenario: fill idx 5, way_en 4'b0100, tag 20'hABCDE, state 2'b11; then look up idx 5 tag 20'hABCDE -> resp_hit=1, way_en=4'b0100, coh_state=2'b11, 2-cycle latency.
REQ-022 Scenario: look up idx 7 with ways 0 and 1 valid (other tags) -> resp_hit=0, way_en=4'b0100, victim_coh_state=0.
REQ-023 Scenario: idx 9 with all 4 ways valid, three consecutive misses -> victims 4'b0001, 4'b0010, 4'b0100; a fourth miss -> 4'b1000, then wrap to 4'b0001.
REQ-024 Scenario: fill_valid and req_valid in the same IDLE cycle -> fill accepted, req_ready=0, the request is accepted the next cycle, no cycle has both meta read and write valid.
REQ-025 Scenario: hold resp_ready=0 for 5 cycles -> resp outputs stable, req_ready=0; drop reset in CMP -> resp_valid=0 and state IDLE.
REQ-026 Scenario: meta_read_ready=0 for the first 64 cycles -> req_ready=0 throughout; the request is accepted on cycle 65.
